// File: rtl/fpu_pkg.sv
// Shared FPU definitions: width-derived format constants, canonical
// IEEE-754 constant patterns for single and double precision, and the
// state encoding of the iterative square-root unit.
package fpu_pkg;

  function automatic int mantissa_size(input int w);
    return (w == 32) ? 23 : 52;
  endfunction

  function automatic int exponent_size(input int w);
    return (w == 32) ? 8 : 11;
  endfunction

  function automatic int bias_of(input int w);
    return (w == 32) ? 127 : 1023;
  endfunction

  localparam logic [63:0] ONE_64        = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] NAN_64        = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] INFINITY_P_64 = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] INFINITY_N_64 = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] ZERO_64       = 64'h0000_0000_0000_0000;

  localparam logic [31:0] ONE_32        = 32'h3F80_0000;
  localparam logic [31:0] NAN_32        = 32'h7FC0_0000;
  localparam logic [31:0] INFINITY_P_32 = 32'h7F80_0000;
  localparam logic [31:0] INFINITY_N_32 = 32'hFF80_0000;
  localparam logic [31:0] ZERO_32       = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    ROUND,
    DONE
  } sqrt_state_t;

endpackage

// File: rtl/fsqrt_classify.sv
// Combinational operand classifier for the square-root unit.
//   i_op        : IEEE-754 operand (BUS_WIDTH bits)
//   o_is_nan    : operand is a NaN
//   o_is_neg    : sign set with nonzero magnitude (includes -inf)
//   o_is_zero   : exponent field zero (+/-0 and flushed subnormals)
//   o_is_inf    : +infinity
//   o_spec_val  : result for the highest-priority special class
//   o_exp_unb   : unbiased exponent (signed)
//   o_exp_odd   : unbiased exponent is odd
module fsqrt_classify
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0]              i_op,
  output logic                              o_is_nan,
  output logic                              o_is_neg,
  output logic                              o_is_zero,
  output logic                              o_is_inf,
  output logic [BUS_WIDTH-1:0]              o_spec_val,
  output logic signed [exponent_size(BUS_WIDTH):0] o_exp_unb,
  output logic                              o_exp_odd
);

  localparam int M = mantissa_size(BUS_WIDTH);
  localparam int E = exponent_size(BUS_WIDTH);
  localparam int B = bias_of(BUS_WIDTH);

  localparam logic [BUS_WIDTH-1:0] NAN_V  =
    (BUS_WIDTH == 32) ? BUS_WIDTH'(NAN_32) : BUS_WIDTH'(NAN_64);
  localparam logic [BUS_WIDTH-1:0] INFP_V =
    (BUS_WIDTH == 32) ? BUS_WIDTH'(INFINITY_P_32) : BUS_WIDTH'(INFINITY_P_64);
  localparam logic [BUS_WIDTH-1:0] ZERO_V =
    (BUS_WIDTH == 32) ? BUS_WIDTH'(ZERO_32) : BUS_WIDTH'(ZERO_64);

  logic         w_sign;
  logic [E-1:0] w_exp;
  logic [M-1:0] w_mant;

  always_comb begin
    w_sign    = i_op[BUS_WIDTH-1];
    w_exp     = i_op[M +: E];
    w_mant    = i_op[M-1:0];
    o_is_nan  = (&w_exp) && (|w_mant);
    o_is_neg  = w_sign && (|i_op[BUS_WIDTH-2:0]);
    o_is_zero = ~(|w_exp);
    o_is_inf  = !w_sign && (&w_exp) && !(|w_mant);
    o_exp_unb = $signed({1'b0, w_exp}) - $signed((E+1)'(B));
    o_exp_odd = o_exp_unb[0];
    if (o_is_nan || o_is_neg) o_spec_val = NAN_V;
    else if (o_is_zero)       o_spec_val = ZERO_V;
    else if (o_is_inf)        o_spec_val = INFP_V;
    else                      o_spec_val = ZERO_V;
  end

endmodule

// File: rtl/fsqrt_iter.sv
// Multi-cycle, correctly rounded (nearest-even) IEEE-754 square root.
// Restoring digit recurrence producing one root bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort, returns to IDLE on the next edge
//   in_valid / in_ready / in1    : operand handshake
//   out_valid / out_ready / out  : result handshake, out held until taken
//   busy       : unit is not IDLE
module fsqrt_iter
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 busy
);

  localparam int M     = mantissa_size(BUS_WIDTH);
  localparam int E     = exponent_size(BUS_WIDTH);
  localparam int B     = bias_of(BUS_WIDTH);
  localparam int ITERS = M + 2;
  localparam int RW    = 2 * ITERS;   // radicand: two bits consumed per step
  localparam int REMW  = ITERS + 3;   // partial remainder incl. brought-down pair
  localparam int CW    = $clog2(ITERS);

  sqrt_state_t          r_state;
  logic [BUS_WIDTH-1:0] r_op;
  logic [BUS_WIDTH-1:0] r_out;
  logic [BUS_WIDTH-1:0] r_spec_val;
  logic                 r_special;
  logic                 r_valid;
  logic                 r_busy;
  logic [RW-1:0]        r_rad;
  logic [REMW-1:0]      r_rem;
  logic [ITERS-1:0]     r_root;
  logic [CW-1:0]        r_cnt;
  logic [E-1:0]         r_exp;

  logic                 w_is_nan, w_is_neg, w_is_zero, w_is_inf, w_special;
  logic [BUS_WIDTH-1:0] w_spec_val;
  logic signed [E:0]    w_exp_unb, w_e_adj, w_e_half;
  logic                 w_exp_odd;
  logic [E-1:0]         w_exp_res;
  logic [M:0]           w_sig;
  logic [RW-1:0]        w_rad_init;
  logic [REMW-1:0]      w_cur, w_sub, w_diff;
  logic                 w_ge;
  logic [M-1:0]         w_mant;
  logic                 w_round_up;
  logic [M:0]           w_mant_inc;
  logic [E-1:0]         w_exp_fin;

  fsqrt_classify #(.BUS_WIDTH(BUS_WIDTH)) u_classify (
    .i_op       (r_op),
    .o_is_nan   (w_is_nan),
    .o_is_neg   (w_is_neg),
    .o_is_zero  (w_is_zero),
    .o_is_inf   (w_is_inf),
    .o_spec_val (w_spec_val),
    .o_exp_unb  (w_exp_unb),
    .o_exp_odd  (w_exp_odd)
  );

  always_comb begin
    w_special = w_is_nan || w_is_neg || w_is_zero || w_is_inf;
    // Odd exponent: fold one factor of two into the radicand.
    w_e_adj   = w_exp_unb - $signed({{E{1'b0}}, w_exp_odd});
    w_e_half  = w_e_adj >>> 1;
    w_exp_res = E'(w_e_half + $signed((E+1)'(B)));
    w_sig     = {1'b1, r_op[M-1:0]};
    // Radicand scaled so the root carries M+1 fraction bits (1.M + guard).
    w_rad_init = w_exp_odd ? {w_sig, {(M+3){1'b0}}}
                           : {1'b0, w_sig, {(M+2){1'b0}}};

    w_cur  = {r_rem[REMW-3:0], r_rad[RW-1 -: 2]};
    w_sub  = {1'b0, r_root, 2'b01};
    w_ge   = (w_cur >= w_sub);
    w_diff = w_cur - w_sub;

    w_mant     = r_root[ITERS-2:1];
    w_round_up = r_root[0] && ((|r_rem) || w_mant[0]);
    w_mant_inc = {1'b0, w_mant} + (M+1)'(w_round_up);
    w_exp_fin  = r_exp + E'(w_mant_inc[M]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_out      <= '0;
      r_spec_val <= '0;
      r_special  <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_rad      <= '0;
      r_rem      <= '0;
      r_root     <= '0;
      r_cnt      <= '0;
      r_exp      <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op    <= in1;
            r_state <= PREP;
            r_busy  <= 1'b1;
          end
        end
        PREP: begin
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
          r_rad      <= w_rad_init;
          r_rem      <= '0;
          r_root     <= '0;
          r_cnt      <= '0;
          r_exp      <= w_exp_res;
          // Specials pass through ROUND so their result lands two edges
          // after acceptance; ROUND forwards the special value unchanged.
          r_state    <= w_special ? ROUND : ITER;
        end
        ITER: begin
          r_rad <= r_rad << 2;
          if (w_ge) begin
            r_rem  <= w_diff;
            r_root <= {r_root[ITERS-2:0], 1'b1};
          end else begin
            r_rem  <= w_cur;
            r_root <= {r_root[ITERS-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITERS - 1)) r_state <= ROUND;
        end
        ROUND: begin
          r_out   <= r_special ? r_spec_val
                               : {1'b0, w_exp_fin, w_mant_inc[M-1:0]};
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !flush;
  assign out_valid = r_valid;
  assign out       = r_out;
  assign busy      = r_busy;

endmodule
